// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode encoding, FSM states and the
// buffered command record.
package alu_pkg;

  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned ALU_DATA_W = 4;
  localparam int unsigned ALU_TAG_W  = 2;

  localparam logic [ALU_OP_W-1:0] OP_CLR  = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'b101;
  localparam logic [ALU_OP_W-1:0] OP_XNOR = 3'b110;
  localparam logic [ALU_OP_W-1:0] OP_SET  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } seq_state_t;

  // Field widths track the ALU datapath; the sequencer's WIDTH/TAG_W must match them.
  typedef struct packed {
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count. Pushes while full and pops while empty are
// ignored; there is no same-cycle bypass.
module alu_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front end for the combinational ALU: buffers commands, issues them one at a time to the
// ALU inputs and returns each captured result with its tag, strictly in order.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_DATA_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = ALU_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ALU_OP_W-1:0]        cmd_op,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [ALU_OP_W-1:0]        alu_s,
  input  logic [WIDTH-1:0]           alu_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [ALU_OP_W-1:0]        rsp_op,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);

  seq_state_t state_q, state_d;
  alu_cmd_t   wr_cmd, head_cmd;
  logic       fifo_full, fifo_empty;
  logic       push, pop, capture, rsp_done;

  logic [WIDTH-1:0]    alu_a_q, alu_b_q, rsp_data_q;
  logic [ALU_OP_W-1:0] alu_s_q, rsp_op_q;
  logic [TAG_W-1:0]    issue_tag_q, rsp_tag_q;
  logic                rsp_valid_q;

  assign wr_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready;

  alu_cmd_fifo #(
    .Width ($bits(alu_cmd_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wr_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = DRIVE;
      DRIVE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = fifo_empty ? IDLE : DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE:  pop = ~fifo_empty;
      DRIVE: capture = 1'b1;
      RESP: begin
        rsp_done = rsp_ready;
        pop      = rsp_ready & ~fifo_empty;
      end
      default: ;
    endcase
  end

  // Issue registers hold the ALU inputs steady between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= OP_CLR;
      issue_tag_q <= '0;
    end else if (pop) begin
      alu_a_q     <= head_cmd.a;
      alu_b_q     <= head_cmd.b;
      alu_s_q     <= head_cmd.op;
      issue_tag_q <= head_cmd.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_tag_q   <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= alu_out;
      rsp_op_q    <= alu_s_q;
      rsp_tag_q   <= issue_tag_q;
    end else if (rsp_done) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and an in-order response
// scoreboard fed with hand-computed results.
module tb_alu_op_sequencer;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [1:0] cmd_tag;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_s;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_op;
  logic [1:0] rsp_tag;
  logic [2:0] fifo_count;
  logic       busy;

  alu_op_sequencer #(
    .WIDTH (4),
    .DEPTH (4),
    .TAG_W (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_tag    (rsp_tag),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  function automatic logic [3:0] alu_model(input logic [2:0] s, input logic [3:0] a,
                                           input logic [3:0] b);
    case (s)
      3'b000:  return 4'h0;
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b110:  return ~(a ^ b);
      default: return 4'hF;
    endcase
  endfunction

  assign alu_out = alu_model(alu_s, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] op;
    logic [1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   phase   = 0;
  int   n_rsp   = 0;
  int   n_push  = 0;
  int   p4_seen = 0;
  int   last_hs = 0;
  int   max_cnt = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: a handshake seen at the negedge completes at the next posedge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (phase == 4 && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_op", 32'(rsp_op), 32'(e.op));
        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
      if (phase == 4) begin
        if (p4_seen > 0) check("stream_gap", 32'(cyc - last_hs), 32'd2);
        last_hs = cyc;
        p4_seen++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] tag, input logic [3:0] exp_data);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (acc) begin
      sb.push_back('{exp_data, op, tag});
      n_push++;
    end else begin
      check("push_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
    end
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [2:0] s_op  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [3:0] s_a   [8] = '{4'h5, 4'h0, 4'hF, 4'h8, 4'h6, 4'h6, 4'h0, 4'hF};
  logic [3:0] s_b   [8] = '{4'h6, 4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'h0, 4'hF};
  logic [3:0] s_exp [8] = '{4'hB, 4'hF, 4'h5, 4'h9, 4'h5, 4'hA, 4'hF, 4'h0};

  initial begin
    bit acc;
    bit stray;
    int rsp0, push0;
    logic [2:0] rop;
    logic [3:0] ra, rb;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit stray;
    int rsp0, push0;
    logic [2:0] rop;
    logic [3:0] ra, rb;

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_alu_s", 32'(alu_s), 32'd0);
    check("reset_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    check("reset_rsp_fields", 32'({rsp_data, rsp_op, rsp_tag}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single ADD with latency check
    phase = 1;
    rsp_ready = 1'b1;
    push_cmd(3'b001, 4'h9, 4'h8, 2'd1, 4'h1);
    @(negedge clk);
    check("t1_valid_e0", 32'(rsp_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_valid_e1", 32'(rsp_valid), 32'd0);
    check("t1_issue", 32'({alu_s, alu_a, alu_b}), 32'({3'b001, 4'h9, 4'h8}));
    @(negedge clk);
    check("t1_valid_e2", 32'(rsp_valid), 32'd1);
    check("t1_rsp", 32'({rsp_data, rsp_op, rsp_tag}), 32'({4'h1, 3'b001, 2'd1}));
    @(posedge clk);
    #1;
    wait_drain("t1_drain");

    // 2: wrap and logic ops
    phase = 2;
    push_cmd(3'b010, 4'h3, 4'h5, 2'd0, 4'hE);
    push_cmd(3'b110, 4'hA, 4'h5, 2'd1, 4'h0);
    push_cmd(3'b101, 4'hA, 4'h5, 2'd2, 4'hF);
    push_cmd(3'b111, 4'h1, 4'h2, 2'd3, 4'hF);
    push_cmd(3'b000, 4'h7, 4'h7, 2'd0, 4'h0);
    push_cmd(3'b011, 4'hA, 4'h6, 2'd1, 4'h2);
    push_cmd(3'b100, 4'hA, 4'h5, 2'd2, 4'hF);
    wait_drain("t2_drain");

    // 3: backpressure fills the FIFO; 6th command is held off
    phase = 3;
    rsp_ready = 1'b0;
    push_cmd(3'b001, 4'h1, 4'h2, 2'd0, 4'h3);
    push_cmd(3'b010, 4'h2, 4'h7, 2'd1, 4'hB);
    push_cmd(3'b011, 4'hC, 4'hA, 2'd2, 4'h8);
    push_cmd(3'b100, 4'h1, 4'h2, 2'd3, 4'h3);
    push_cmd(3'b101, 4'hF, 4'h3, 2'd0, 4'hC);
    cmd_valid = 1'b1;
    cmd_op = 3'b001;
    cmd_a = 4'hF;
    cmd_b = 4'hF;
    cmd_tag = 2'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_count", 32'(fifo_count), 32'd4);
      check("t3_cmd_ready", 32'(cmd_ready), 32'd0);
      check("t3_hold", 32'({rsp_valid, rsp_data, rsp_op, rsp_tag}),
            32'({1'b1, 4'h3, 3'b001, 2'd0}));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("t3_sixth_accepted", 32'(acc), 32'd1);
    if (acc) sb.push_back('{4'hE, 3'b001, 2'd1});
    wait_drain("t3_drain");

    // 4: streaming at one command per two cycles
    phase = 4;
    p4_seen = 0;
    max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      push_cmd(s_op[i], s_a[i], s_b[i], 2'(i), s_exp[i]);
      @(posedge clk);
      #1;
    end
    wait_drain("t4_drain");
    phase = 0;
    check("t4_responses", 32'(p4_seen), 32'd8);
    check("t4_max_count_le2", 32'(max_cnt <= 2), 32'd1);

    // 5: asynchronous reset while a response is stalled and three entries are buffered
    phase = 5;
    rsp_ready = 1'b0;
    push_cmd(3'b001, 4'h1, 4'h1, 2'd0, 4'h2);
    push_cmd(3'b001, 4'h2, 4'h2, 2'd1, 4'h4);
    push_cmd(3'b001, 4'h3, 4'h3, 2'd2, 4'h6);
    push_cmd(3'b001, 4'h4, 4'h4, 2'd3, 4'h8);
    @(negedge clk);
    check("t5_pre_count", 32'(fifo_count), 32'd3);
    check("t5_pre_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_alu_s", 32'(alu_s), 32'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stray = stray | rsp_valid | busy;
    end
    check("t5_no_stale", 32'(stray), 32'd0);
    @(posedge clk);
    #1;

    // 6: random rsp_ready with overlapping push/pop
    phase = 6;
    rsp0 = n_rsp;
    push0 = n_push;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      push_cmd(rop, ra, rb, 2'(i), alu_model(rop, ra, rb));
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    wait_drain("t6_drain");
    check("t6_no_loss", 32'(n_rsp - rsp0), 32'(n_push - push0));
    check("t6_count40", 32'(n_push - push0), 32'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side front end for the 4-bit combinational ALU. Accepts operation commands (opcode, operands, tag) over a valid/ready handshake and buffers them in a small FIFO. Issues each command to the ALU's A/B/S inputs, captures the ALU result and returns it with its tag over a valid/ready response channel. Sits between the control logic that produces ALU work and the ALU instance; ordering is strictly preserved.

Parameters:
WIDTH, 4, operand/result width; must equal the ALU datapath width
DEPTH, 4, command FIFO depth in entries; power of 2, >= 2
TAG_W, 2, width of the command/response tag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  3  ALU opcode (S encoding)
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_tag  in  TAG_W  caller tag, returned unchanged
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_s  out  3  to ALU S
alu_out  in  WIDTH  ALU result (combinational from alu_a/b/s)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  captured ALU result
rsp_op  out  3  opcode of this response
rsp_tag  out  TAG_W  tag of this response
fifo_count  out  $clog2(DEPTH+1)  entries currently buffered
busy  out  1  state != IDLE or fifo_count != 0

Behaviour:
- Reset (async, rst_n=0): FIFO emptied (pointers/count 0), state IDLE, rsp_valid=0, rsp_data/rsp_op/rsp_tag=0, alu_a/alu_b=0, alu_s=3'b000 (Clear), busy=0. Any in-flight command and any pending response are dropped; nothing is replayed after reset release.
- Push: on a rising edge with cmd_valid && cmd_ready, write {op,a,b,tag} at wr_ptr. cmd_ready = (fifo_count != DEPTH). There is no pop-aware bypass: when full, cmd_ready stays 0 even in a pop cycle.
- Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave fifo_count unchanged.
- alu_a/alu_b/alu_s are registered issue registers. They change only on a pop and hold their last value otherwise.
- FSM, 3 states:
  IDLE: if fifo_count != 0, pop the head into the issue registers -> DRIVE.
  DRIVE: ALU inputs are stable for one full cycle. At the edge, rsp_data <= alu_out, rsp_op <= alu_s, rsp_tag <= issued tag, rsp_valid <= 1 -> RESP.
  RESP: hold all rsp_* stable while !rsp_ready. On rsp_valid && rsp_ready: if fifo_count != 0, pop the next command -> DRIVE (rsp_valid <= 0); else rsp_valid <= 0 -> IDLE.
- Latency: command accepted at edge E0 into an empty, idle block -> popped at E1 -> rsp_valid high after E2.
- Throughput: one response per 2 cycles with rsp_ready held high.
- No arithmetic in this block. Results are whatever the ALU returns, i.e. truncated modulo 2^WIDTH. The opcode is passed through unchecked; all 8 codes are legal.
- Commands pushed while a response is stalled are buffered up to DEPTH. With rsp_ready=0 the block holds at most DEPTH+1 commands (DEPTH buffered + 1 in RESP).

Decomposition:
- Shared package alu_pkg:
  - ALU_OP_W=3
  - opcode constants OP_CLR=000, OP_ADD=001, OP_SUB=010, OP_AND=011, OP_OR=100, OP_XOR=101, OP_XNOR=110, OP_SET=111
  - seq_state_t enum {IDLE, DRIVE, RESP}
  - the command struct (op, a, b, tag)
- One sub-module: alu_cmd_fifo, a synchronous FIFO parameterised by width/DEPTH with full/empty/count and async active-low reset.
- The FSM and issue/response registers live in the top module.

Test Plan:
1. Single ADD: a=9, b=8, op=001, tag=1, rsp_ready=1 -> rsp_valid after 2nd edge following accept; rsp_data=0x1, rsp_op=001, rsp_tag=1.
2. SUB wrap and logic ops: (3,5,010) -> 0xE; (0xA,0x5,110) -> 0x0; (0xA,0x5,101) -> 0xF; op 111 -> 0xF; op 000 -> 0x0.
3. Backpressure, rsp_ready=0, DEPTH=4: push 6 commands back-to-back. The first enters RESP; commands 2-5 fill the FIFO; fifo_count=4; cmd_ready=0, so the 6th is held. rsp_* are stable for 20 cycles. Then release rsp_ready: all 6 responses are returned in tag order.
4. Streaming: 8 commands with tags 0,1,2,3,0,1,2,3 and rsp_ready=1 -> responses every 2 cycles, in order, with correct data; fifo_count never exceeds 2.
5. Reset mid-operation: drive rst_n low asynchronously while in RESP with 3 entries buffered -> rsp_valid=0, fifo_count=0, alu_s=000 immediately. After release: cmd_ready=1, busy=0, and no stale responses appear.
6. Random rsp_ready toggling with simultaneous push/pop on a non-full FIFO -> a scoreboard matches every response against a model of the 8 ALU ops, with no loss or duplication.
